// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the InvMixColumns stage.
package aes_pkg;

  typedef logic [0:127] aes_state_t;
  typedef logic [0:31]  aes_col_t;

  localparam int AES_NCOLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } imc_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column; byte s0 sits in bits [0:7].
module inv_mix_single_column
  import aes_pkg::*;
(
  input  aes_col_t col_i,
  output aes_col_t col_o
);

  logic [7:0] s0, s1, s2, s3;

  assign s0 = col_i[0:7];
  assign s1 = col_i[8:15];
  assign s2 = col_i[16:23];
  assign s3 = col_i[24:31];

  assign col_o = {gf_mul14(s0) ^ gf_mul11(s1) ^ gf_mul13(s2) ^ gf_mul9(s3),
                  gf_mul9(s0)  ^ gf_mul14(s1) ^ gf_mul11(s2) ^ gf_mul13(s3),
                  gf_mul13(s0) ^ gf_mul9(s1)  ^ gf_mul14(s2) ^ gf_mul11(s3),
                  gf_mul11(s0) ^ gf_mul13(s1) ^ gf_mul9(s2)  ^ gf_mul14(s3)};

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one state in flight, COLS_PER_CYCLE columns
// (1, 2 or 4) transformed per clock, valid/ready on both sides.
// Optional macro INV_MIX_BYPASS_EN adds a 'bypass' input that routes an
// accepted state straight to DONE unchanged (final decryption round).
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_data,
  output logic       busy
`ifdef INV_MIX_BYPASS_EN
  ,
  input  logic       bypass
`endif
);

  // Counter step wraps naturally in 2 bits (4 -> 0); LAST is the start
  // column of the final group, i.e. the group that contains column 3.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(AES_NCOLS - COLS_PER_CYCLE);

  imc_state_e state_q, state_d;
  logic [1:0] col_cnt_q, col_cnt_d;
  aes_state_t work_q, work_d;
  aes_state_t out_data_q, out_data_d;
  aes_state_t work_mix;
  logic       accept_byp;

  logic [1:0] col_idx [COLS_PER_CYCLE];
  aes_col_t   col_in  [COLS_PER_CYCLE];
  aes_col_t   col_out [COLS_PER_CYCLE];

`ifdef INV_MIX_BYPASS_EN
  assign accept_byp = bypass;
`else
  assign accept_byp = 1'b0;
`endif

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = col_cnt_q + 2'(g);
    assign col_in[g]  = work_q[{col_idx[g], 5'b00000} +: 32];
    inv_mix_single_column u_col (
      .col_i (col_in[g]),
      .col_o (col_out[g])
    );
  end

  // Working state with the selected columns replaced by their transform.
  always_comb begin
    work_mix = work_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      work_mix[{col_idx[j], 5'b00000} +: 32] = col_out[j];
    end
  end

  // Next-state and handshake outputs of the IDLE/ITER/DONE controller.
  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    work_d     = work_q;
    out_data_d = out_data_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d    = in_data;
          col_cnt_d = 2'd0;
          if (accept_byp) begin
            out_data_d = in_data;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        busy      = 1'b1;
        work_d    = work_mix;
        col_cnt_d = col_cnt_q + CNT_STEP;
        if (col_cnt_q == CNT_LAST) begin
          out_data_d = work_mix;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and the visible output register; reset discards any state in flight.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      col_cnt_q  <= 2'd0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      col_cnt_q  <= col_cnt_d;
      out_data_q <= out_data_d;
    end
  end

  // Working register is pure data; its content is ignored outside ITER.
  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

  assign out_data = out_data_q;

endmodule
